// File: rtl/rv32_mem_pkg.sv
// -----------------------------------------------------------------------------
// rv32_mem_pkg
// Shared constants and types for the RV32 memory-access stage:
//   - branch-op encodings driven by the execute stage
//   - load/store width encodings
//   - memory-access FSM state enum
// -----------------------------------------------------------------------------
package rv32_mem_pkg;

  localparam logic [1:0] RV32_BRANCH_OP_NEVER    = 2'd0;
  localparam logic [1:0] RV32_BRANCH_OP_ZERO     = 2'd1;
  localparam logic [1:0] RV32_BRANCH_OP_NON_ZERO = 2'd2;
  localparam logic [1:0] RV32_BRANCH_OP_ALWAYS   = 2'd3;

  localparam logic [1:0] RV32_MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] RV32_MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] RV32_MEM_WIDTH_WORD = 2'd2;

  // ACCESS: bus request follows the execute-stage controls.
  // DONE:   access finished while the pipeline was stalled; data is held.
  typedef enum logic {
    ACCESS = 1'b0,
    DONE   = 1'b1
  } mem_state_e;

endpackage

// File: rtl/rv32_mem_if.sv
// -----------------------------------------------------------------------------
// rv32_mem_if
// Data-bus interface between the memory-access stage (master) and the data
// memory / bus slave (slave).
//   data_address_out      word-aligned byte address
//   data_read_out         read request
//   data_write_out        write request
//   data_write_mask_out   byte strobes, bit n enables byte lane n
//   data_write_value_out  lane-aligned store data
//   data_read_value_in    read data returned by the slave
//   data_ready_in         access completes this cycle
// -----------------------------------------------------------------------------
interface rv32_mem_if;

  logic [31:0] data_address_out;
  logic        data_read_out;
  logic        data_write_out;
  logic [3:0]  data_write_mask_out;
  logic [31:0] data_write_value_out;
  logic [31:0] data_read_value_in;
  logic        data_ready_in;

  modport master (
    output data_address_out, data_read_out, data_write_out,
           data_write_mask_out, data_write_value_out,
    input  data_read_value_in, data_ready_in
  );

  modport slave (
    input  data_address_out, data_read_out, data_write_out,
           data_write_mask_out, data_write_value_out,
    output data_read_value_in, data_ready_in
  );

endinterface

// File: rtl/rv32_mem_align.sv
// -----------------------------------------------------------------------------
// rv32_mem_align
// Purely combinational byte-lane logic for the memory stage.
//   i_width        0=byte, 1=half, 2=word (3 is treated as word)
//   i_off          low address bits (byte offset within the word)
//   i_zero_extend  1: zero-extend loads, 0: sign-extend
//   i_store_data   rs2 value to be stored
//   i_load_data    raw word returned by the bus
//   o_mask         byte strobes for the store
//   o_store_value  store data replicated onto every candidate lane
//   o_load_value   extracted and extended load result
// -----------------------------------------------------------------------------
module rv32_mem_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic [1:0]  i_off,
  input  logic        i_zero_extend,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_data,
  output logic [3:0]  o_mask,
  output logic [31:0] o_store_value,
  output logic [31:0] o_load_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfwords only use off[1]; off[0] is truncated for misaligned accesses.
  assign w_byte = i_load_data[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_load_data[31:16] : i_load_data[15:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    o_mask        = 4'b1111;
    o_store_value = i_store_data;
    o_load_value  = i_load_data;
    unique case (i_width)
      RV32_MEM_WIDTH_BYTE: begin
        o_mask        = 4'b0001 << i_off;
        o_store_value = {4{i_store_data[7:0]}};
        o_load_value  = {{24{~i_zero_extend & w_byte[7]}}, w_byte};
      end
      RV32_MEM_WIDTH_HALF: begin
        o_mask        = i_off[1] ? 4'b1100 : 4'b0011;
        o_store_value = {2{i_store_data[15:0]}};
        o_load_value  = {{16{~i_zero_extend & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32_mem.sv
// -----------------------------------------------------------------------------
// rv32_mem
// RV32 memory-access stage. Consumes the registered execute-stage outputs,
// drives the data bus for loads/stores, resolves branches and registers the
// writeback-stage inputs. No functional parameters.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   stall_in / flush_in   hazard unit: hold outputs / register a bubble
//   mem_*_in              access type, width and load extension
//   branch_op_in          branch condition (see rv32_mem_pkg)
//   rd_in, rd_write_in    destination register
//   result_in             ALU result / effective address
//   rs2_value_in          store data
//   branch_pc_in          branch target
//   bus                   data bus (rv32_mem_if.master)
//   stall_out             bus access outstanding (combinational)
//   branch_taken_out      branch decision (combinational)
//   branch_pc_out         branch target pass-through
//   rd_out, rd_write_out, rd_value_out   registered writeback inputs
//
// Optional feature, macro RV32_MEM_MISALIGN_TRAP_EN: adds misaligned_out and
// suppresses misaligned accesses instead of truncating the address.
// -----------------------------------------------------------------------------
module rv32_mem
  import rv32_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [1:0]        mem_width_in,
  input  logic              mem_zero_extend_in,
  input  logic [1:0]        branch_op_in,
  input  logic [4:0]        rd_in,
  input  logic              rd_write_in,
  input  logic [31:0]       result_in,
  input  logic [31:0]       rs2_value_in,
  input  logic [31:0]       branch_pc_in,
  rv32_mem_if.master        bus,
  output logic              stall_out,
  output logic              branch_taken_out,
  output logic [31:0]       branch_pc_out,
  output logic [4:0]        rd_out,
  output logic              rd_write_out,
  output logic [31:0]       rd_value_out
`ifdef RV32_MEM_MISALIGN_TRAP_EN
  ,
  output logic              misaligned_out
`endif
);

  mem_state_e  r_state;
  mem_state_e  w_state_next;
  logic [31:0] r_hold_value;
  logic [31:0] w_load_extract;
  logic [31:0] w_load_value;
  logic [1:0]  w_off;
  logic        w_misaligned;
  logic        w_mem_op;
  logic        w_update;

  assign w_off = result_in[1:0];

`ifdef RV32_MEM_MISALIGN_TRAP_EN
  assign w_misaligned = (mem_read_in | mem_write_in) &
                        (((mem_width_in == RV32_MEM_WIDTH_HALF) & w_off[0]) |
                         ((mem_width_in == RV32_MEM_WIDTH_WORD) & (w_off != 2'b00)));
  assign misaligned_out = w_misaligned;
`else
  assign w_misaligned = 1'b0;
`endif

  // A misaligned access (trap build only) behaves as if no bus access exists.
  assign w_mem_op = (mem_read_in | mem_write_in) & ~w_misaligned;

  rv32_mem_align u_align (
    .i_width       (mem_width_in),
    .i_off         (w_off),
    .i_zero_extend (mem_zero_extend_in),
    .i_store_data  (rs2_value_in),
    .i_load_data   (bus.data_read_value_in),
    .o_mask        (bus.data_write_mask_out),
    .o_store_value (bus.data_write_value_out),
    .o_load_value  (w_load_extract)
  );

  assign bus.data_address_out = {result_in[31:2], 2'b00};

  // Branch resolution does not depend on the stall state.
  assign branch_taken_out = (branch_op_in == RV32_BRANCH_OP_ALWAYS) |
                            ((branch_op_in == RV32_BRANCH_OP_ZERO)     & (result_in == 32'd0)) |
                            ((branch_op_in == RV32_BRANCH_OP_NON_ZERO) & (result_in != 32'd0));
  assign branch_pc_out    = branch_pc_in;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!reset_n) r_state <= ACCESS;
    else          r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ACCESS:  if (w_mem_op && bus.data_ready_in && stall_in) w_state_next = DONE;
      DONE:    if (!stall_in) w_state_next = ACCESS;
      default: w_state_next = ACCESS;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // In DONE the access has already completed, so the request is dropped even
  // though the execute stage still presents the same controls.
  always_comb begin
    bus.data_read_out  = 1'b0;
    bus.data_write_out = 1'b0;
    stall_out          = 1'b0;
    if (r_state == ACCESS) begin
      bus.data_read_out  = mem_read_in  & ~w_misaligned;
      bus.data_write_out = mem_write_in & ~w_misaligned;
      stall_out          = w_mem_op & ~bus.data_ready_in;
    end
  end

  // Load data captured when the access completes under an external stall;
  // the bus is free to change its read data afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_value <= 32'd0;
    end else if ((r_state == ACCESS) && w_mem_op && bus.data_ready_in && stall_in) begin
      r_hold_value <= w_load_extract;
    end
  end

  assign w_load_value = (r_state == DONE) ? r_hold_value : w_load_extract;
  assign w_update     = ~stall_in & ~stall_out;

  // ---------------- writeback registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_out       <= 5'd0;
      rd_write_out <= 1'b0;
      rd_value_out <= 32'd0;
    end else if (w_update) begin
      rd_out       <= rd_in;
      rd_write_out <= rd_write_in & ~flush_in & ~w_misaligned;
      rd_value_out <= mem_read_in ? w_load_value : result_in;
    end
  end

endmodule

// File: tb/tb_rv32_mem.sv
// -----------------------------------------------------------------------------
// tb_rv32_mem
// Self-checking bench for rv32_mem. The driver acts as execute stage, hazard
// unit and bus slave; expected writeback results go into a queue that an
// independent monitor pops whenever the stage accepts an instruction.
// Build with +define+RV32_MEM_MISALIGN_TRAP_EN to cover the trap variant.
// -----------------------------------------------------------------------------
module tb_rv32_mem;
  import rv32_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_in = 1'b0, flush_in = 1'b0;
  logic        mem_read_in = 1'b0, mem_write_in = 1'b0;
  logic [1:0]  mem_width_in = 2'd0;
  logic        mem_zero_extend_in = 1'b0;
  logic [1:0]  branch_op_in = 2'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        rd_write_in = 1'b0;
  logic [31:0] result_in = 32'd0, rs2_value_in = 32'd0, branch_pc_in = 32'd0;
  logic        stall_out, branch_taken_out;
  logic [31:0] branch_pc_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] rd_value_out;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
  logic        misaligned_out;
`endif

  rv32_mem_if bus ();

  rv32_mem dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .stall_in           (stall_in),
    .flush_in           (flush_in),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .mem_width_in       (mem_width_in),
    .mem_zero_extend_in (mem_zero_extend_in),
    .branch_op_in       (branch_op_in),
    .rd_in              (rd_in),
    .rd_write_in        (rd_write_in),
    .result_in          (result_in),
    .rs2_value_in       (rs2_value_in),
    .branch_pc_in       (branch_pc_in),
    .bus                (bus),
    .stall_out          (stall_out),
    .branch_taken_out   (branch_taken_out),
    .branch_pc_out      (branch_pc_out),
    .rd_out             (rd_out),
    .rd_write_out       (rd_write_out),
    .rd_value_out       (rd_value_out)
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    ,
    .misaligned_out     (misaligned_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rd_write;
    logic [31:0] value;
    logic        check_value;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic tb_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [31:0] data, input logic [1:0] width,
                                             input logic [1:0] off, input logic zx);
    int unsigned shift_bytes;
    logic [31:0] v;
    shift_bytes = (width == 2'd0) ? off : (width == 2'd1) ? (off & 2'd2) : 0;
    v = data >> (8 * shift_bytes);
    if (width == 2'd0) begin
      v = v & 32'hFF;
      if (!zx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (width == 2'd1) begin
      v = v & 32'hFFFF;
      if (!zx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_mask(input logic [1:0] width, input logic [1:0] off);
    if (width == 2'd0) return 32'd1 << off;
    if (width == 2'd1) return 32'd3 << (off & 2'd2);
    return 32'hF;
  endfunction

  function automatic logic [31:0] model_store(input logic [1:0] width, input logic [31:0] rs2);
    if (width == 2'd0) return (rs2 & 32'hFF) * 32'h0101_0101;
    if (width == 2'd1) return (rs2 & 32'hFFFF) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic model_taken(input logic [1:0] op, input logic [31:0] res);
    return (op == 2'd3) || (op == 2'd1 && res == 0) || (op == 2'd2 && res != 0);
  endfunction

  // ---------------- driver: one instruction until accepted ----------------
  task automatic issue(input logic rd_en, input logic wr_en, input logic [1:0] width,
                       input logic zx, input logic [1:0] bop, input logic [4:0] rd,
                       input logic rdw, input logic [31:0] result, input logic [31:0] rs2,
                       input logic [31:0] bpc, input logic [31:0] rdata,
                       input int lat, input int stl, input logic flush);
    logic [1:0] off;
    logic       mis, eff, acc, done;
    int         lx, c;
    exp_t       e;
    off = result[1:0];
    mis = 1'b0;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    mis = (rd_en || wr_en) && ((width == 2'd1 && off[0]) || (width == 2'd2 && off != 2'd0));
`endif
    eff = (rd_en || wr_en) && !mis;
    lx  = eff ? lat : 0;

    mem_read_in = rd_en; mem_write_in = wr_en; mem_width_in = width;
    mem_zero_extend_in = zx; branch_op_in = bop; rd_in = rd; rd_write_in = rdw;
    result_in = result; rs2_value_in = rs2; branch_pc_in = bpc; flush_in = flush;
    tb_valid = 1'b1;

    e.rd          = rd;
    e.rd_write    = rdw && !flush && !mis;
    e.value       = rd_en ? model_load(rdata, width, off, zx) : result;
    e.check_value = !(mis && rd_en);
    exp_q.push_back(e);

    c = 0;
    done = 1'b0;
    while (!done) begin
      bus.data_ready_in      = eff && (c == lat);
      bus.data_read_value_in = (eff && c == lat) ? rdata : $urandom();
      stall_in               = (c >= lx) && (c < lx + stl);
      #1;
      check("stall_out", 32'(stall_out), 32'(eff && c < lat));
      check("data_read_out", 32'(bus.data_read_out), 32'(rd_en && !mis && c <= lat));
      check("data_write_out", 32'(bus.data_write_out), 32'(wr_en && !mis && c <= lat));
      check("branch_taken", 32'(branch_taken_out), 32'(model_taken(bop, result)));
`ifdef RV32_MEM_MISALIGN_TRAP_EN
      check("misaligned_out", 32'(misaligned_out), 32'(mis));
`endif
      if (c == 0) begin
        check("branch_pc", branch_pc_out, bpc);
        check("data_address", bus.data_address_out, result & 32'hFFFF_FFFC);
        if (wr_en) begin
          check("write_mask", 32'(bus.data_write_mask_out), model_mask(width, off));
          check("write_value", bus.data_write_value_out, model_store(width, rs2));
        end
      end
      @(negedge clk);
      acc = !stall_in && !stall_out;
      @(posedge clk);
      #1;
      if (acc) begin
        check("accept_cycle", 32'(c), 32'(lx + stl));
        done = 1'b1;
      end else if (c > lx + stl + 8) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: actual=not accepted after %0d cycles required=%0d", c, lx + stl);
        done = 1'b1;
      end
      c++;
    end
    bus.data_ready_in = 1'b0;
    stall_in = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_acc;
    exp_t e;
    prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_acc) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL monitor_unexpected: actual=writeback with empty queue required=none");
        end else begin
          e = exp_q.pop_front();
          check("rd_out", 32'(rd_out), 32'(e.rd));
          check("rd_write_out", 32'(rd_write_out), 32'(e.rd_write));
          if (e.check_value) check("rd_value_out", rd_value_out, e.value);
        end
      end
      prev_acc = reset_n && tb_valid && !stall_in && !stall_out;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.data_ready_in      = 1'b0;
    bus.data_read_value_in = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_out", 32'(rd_out), 32'd0);
    check("reset_rd_write", 32'(rd_write_out), 32'd0);
    check("reset_rd_value", rd_value_out, 32'd0);
    check("reset_stall_out", 32'(stall_out), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // rd_en wr_en width zx bop rd rdw result rs2 bpc rdata lat stl flush
    issue(1, 0, 2'd2, 0, RV32_BRANCH_OP_NEVER, 5'd5, 1, 32'h100, 0, 32'h40, 32'hDEAD_BEEF, 2, 0, 0);
    issue(1, 0, 2'd0, 0, RV32_BRANCH_OP_NEVER, 5'd6, 1, 32'h103, 0, 32'h44, 32'h80FF_FFFF, 1, 0, 0);
    issue(1, 0, 2'd0, 1, RV32_BRANCH_OP_NEVER, 5'd7, 1, 32'h103, 0, 32'h48, 32'h80FF_FFFF, 1, 0, 0);
    issue(0, 1, 2'd1, 0, RV32_BRANCH_OP_NEVER, 5'd0, 0, 32'h202, 32'h1234_ABCD, 32'h4C, 0, 1, 0, 0);
    issue(1, 0, 2'd2, 0, RV32_BRANCH_OP_NEVER, 5'd8, 1, 32'h300, 0, 32'h50, 32'hCAFE_F00D, 1, 3, 0);
    issue(1, 0, 2'd1, 0, RV32_BRANCH_OP_NEVER, 5'd9, 1, 32'h306, 0, 32'h54, 32'h9ABC_1234, 0, 2, 0);
    issue(0, 0, 2'd2, 0, RV32_BRANCH_OP_ZERO, 5'd10, 1, 32'h0, 0, 32'h800, 0, 0, 0, 0);
    issue(0, 0, 2'd2, 0, RV32_BRANCH_OP_NON_ZERO, 5'd11, 1, 32'h0, 0, 32'h900, 0, 0, 0, 0);
    issue(0, 0, 2'd2, 0, RV32_BRANCH_OP_ALWAYS, 5'd12, 1, 32'h55, 0, 32'hA00, 0, 0, 0, 1);
    issue(1, 0, 2'd2, 0, RV32_BRANCH_OP_NEVER, 5'd0, 1, 32'h400, 0, 32'h58, 32'h1111_2222, 1, 0, 0);
    issue(1, 0, 2'd2, 0, RV32_BRANCH_OP_NEVER, 5'd13, 1, 32'h101, 0, 32'h5C, 32'h7654_3210, 1, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int          kind;
      logic [31:0] res;
      kind = $urandom_range(0, 2);
      res  = $urandom();
      if ($urandom_range(0, 3) == 0) res = 32'd0;
      issue(kind == 0, kind == 1, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 5'($urandom()), 1'($urandom_range(0, 1)), res,
            $urandom(), $urandom(), $urandom(), $urandom_range(0, 3), $urandom_range(0, 2),
            $urandom_range(0, 7) == 0);
    end

    tb_valid = 1'b0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; rd_write_in = 1'b0; flush_in = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Complete a load under stall so the FSM sits in DONE, then reset.
    rd_in = 5'd3; rd_write_in = 1'b1; result_in = 32'h100; mem_width_in = 2'd2;
    mem_read_in = 1'b1; stall_in = 1'b1;
    bus.data_ready_in = 1'b1; bus.data_read_value_in = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    check("done_read_dropped", 32'(bus.data_read_out), 32'd0);
    check("done_stall_out", 32'(stall_out), 32'd0);
    bus.data_ready_in = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_rd_out", 32'(rd_out), 32'd0);
    check("midreset_rd_write", 32'(rd_write_out), 32'd0);
    check("midreset_rd_value", rd_value_out, 32'd0);
    check("midreset_access_read", 32'(bus.data_read_out), 32'd1);
    check("midreset_stall_out", 32'(stall_out), 32'd1);
    mem_read_in = 1'b0; stall_in = 1'b0; rd_write_in = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $fatal(1, "timeout");
  end

endmodule
